hvac_sequencer: RTL and testbench

- Sits between the hysteresis thermostat (heating/cooling request pair) and the plant drives.
- Sequences heater, cooler and fan with a fan pre-run before each run and a fan post-run after it.
- Enforces a minimum compressor/heater on-time, then a mandatory rest period, so the plant is never short-cycled.
- Rejects simultaneous heat and cool requests.

---
 rtl/hvac_sequencer.sv | 131 +++++++++++++
 tb/tb_hvac_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hvac_sequencer.sv
// HVAC plant sequencer: fan pre-run, heater/cooler run with minimum on-time,
// fan post-run and a mandatory rest period between runs.
module hvac_sequencer #(
    parameter int unsigned MIN_ON   = 8,
    parameter int unsigned MIN_OFF  = 6,
    parameter int unsigned FAN_LEAD = 2,
    parameter int unsigned FAN_LAG  = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       heat_req,
    input  logic       cool_req,
    output logic       heater_on,
    output logic       cooler_on,
    output logic       fan_on,
    output logic [2:0] state,
    output logic       conflict,
    output logic       resting
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFanPre  = 3'd1,
        StRunHeat = 3'd2,
        StRunCool = 3'd3,
        StFanPost = 3'd4,
        StRest    = 3'd5
    } state_e;

    // Last counter value of each timed phase; exit happens on the edge that sees it.
    localparam logic [CNT_W-1:0] LeadLast = CNT_W'(FAN_LEAD - 1);
    localparam logic [CNT_W-1:0] OnLast   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] LagLast  = CNT_W'(FAN_LAG - 1);
    localparam logic [CNT_W-1:0] OffLast  = CNT_W'(MIN_OFF - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;  // 1 = heat, 0 = cool
    logic             heater_q, heater_d;
    logic             cooler_q, cooler_d;
    logic             fan_q, fan_d;
    logic             conflict_q, conflict_d;
    logic             resting_q, resting_d;
    logic             mode_req;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        mode_req = mode_q ? heat_req : cool_req;

        case (state_q)
            StIdle: begin
                if (enable && (heat_req ^ cool_req)) begin
                    state_d = StFanPre;
                    mode_d  = heat_req;
                end
            end
            StFanPre: begin
                if (!mode_req || !enable) begin
                    state_d = StFanPost;
                end else if (cnt_q >= LeadLast) begin
                    state_d = mode_q ? StRunHeat : StRunCool;
                end
            end
            StRunHeat, StRunCool: begin
                if ((cnt_q >= OnLast) && (!mode_req || !enable)) begin
                    state_d = StFanPost;
                end
            end
            StFanPost: begin
                if (cnt_q >= LagLast) begin
                    state_d = StRest;
                end
            end
            StRest: begin
                if (cnt_q >= OffLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Outputs decoded from the next state so they register alongside it.
        heater_d   = (state_d == StRunHeat);
        cooler_d   = (state_d == StRunCool);
        fan_d      = (state_d == StFanPre) || (state_d == StRunHeat) ||
                     (state_d == StRunCool) || (state_d == StFanPost);
        conflict_d = (state_d == StIdle) && heat_req && cool_req;
        resting_d  = (state_d == StRest);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mode_q     <= 1'b1;
            heater_q   <= 1'b0;
            cooler_q   <= 1'b0;
            fan_q      <= 1'b0;
            conflict_q <= 1'b0;
            resting_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            heater_q   <= heater_d;
            cooler_q   <= cooler_d;
            fan_q      <= fan_d;
            conflict_q <= conflict_d;
            resting_q  <= resting_d;
        end
    end

    assign state     = state_q;
    assign heater_on = heater_q;
    assign cooler_on = cooler_q;
    assign fan_on    = fan_q;
    assign conflict  = conflict_q;
    assign resting   = resting_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Scoreboard bench for hvac_sequencer: stimulus pushes the hand-computed state
// expected after each edge; a monitor pops and compares one entry per cycle.
module tb_hvac_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       heat_req;
    logic       cool_req;
    logic       heater_on;
    logic       cooler_on;
    logic       fan_on;
    logic [2:0] state;
    logic       conflict;
    logic       resting;

    typedef struct packed {
        logic [2:0] st;
        logic       conf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    hvac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .heat_req  (heat_req),
        .cool_req  (cool_req),
        .heater_on (heater_on),
        .cooler_on (cooler_on),
        .fan_on    (fan_on),
        .state     (state),
        .conflict  (conflict),
        .resting   (resting)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Inputs change at negedge; entry describes the state after the next posedge.
    task automatic step(input logic h, input logic c, input logic e,
                        input logic [2:0] st, input logic conf);
        exp_t x;
        @(negedge clk);
        heat_req = h;
        cool_req = c;
        enable   = e;
        x.st     = st;
        x.conf   = conf;
        exp_q.push_back(x);
    endtask

    task automatic run(input logic h, input logic c, input logic e,
                       input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) step(h, c, e, st, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: expected drives follow directly from the expected state code.
    initial begin
        exp_t       x;
        logic [4:0] exp_o;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                exp_o = {x.st == 3'd2, x.st == 3'd3, (x.st >= 3'd1) && (x.st <= 3'd4),
                         x.conf, x.st == 3'd5};
                chk("state", int'(state), int'(x.st));
                chk("outs{htr,clr,fan,cfl,rest}",
                    int'({heater_on, cooler_on, fan_on, conflict, resting}), int'(exp_o));
                chk("heat_cool_exclusive", int'(heater_on && cooler_on), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        enable   = 1'b0;
        heat_req = 1'b0;
        cool_req = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({heater_on, cooler_on, fan_on, conflict, resting}), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with inputs low, then a request while disabled is ignored
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        run(1'b1, 1'b0, 1'b0, 3'd0, 3);

        // Heat run: request held 20 edges, then dropped
        run(1'b1, 1'b0, 1'b1, 3'd1, 2);
        run(1'b1, 1'b0, 1'b1, 3'd2, 18);
        run(1'b0, 1'b0, 1'b1, 3'd4, 3);
        run(1'b0, 1'b0, 1'b1, 3'd5, 6);
        run(1'b0, 1'b0, 1'b1, 3'd0, 2);

        // Min-on: 3-cycle cool pulse still gives 8 cooler cycles
        run(1'b0, 1'b1, 1'b1, 3'd1, 2);
        run(1'b0, 1'b1, 1'b1, 3'd3, 1);
        run(1'b0, 1'b0, 1'b1, 3'd3, 7);
        run(1'b0, 1'b0, 1'b1, 3'd4, 3);
        run(1'b0, 1'b0, 1'b1, 3'd5, 6);
        run(1'b0, 1'b0, 1'b1, 3'd0, 1);

        // Conflict: both requests in IDLE, then cool drops and heat starts
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        run(1'b1, 1'b0, 1'b1, 3'd1, 2);
        run(1'b1, 1'b0, 1'b1, 3'd2, 8);
        run(1'b0, 1'b0, 1'b1, 3'd4, 3);
        run(1'b0, 1'b0, 1'b1, 3'd5, 6);
        run(1'b0, 1'b0, 1'b1, 3'd0, 1);

        // Abort in pre-run: heater never comes on
        step(1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        run(1'b0, 1'b0, 1'b1, 3'd4, 3);
        run(1'b0, 1'b0, 1'b1, 3'd5, 6);
        run(1'b0, 1'b0, 1'b1, 3'd0, 1);

        // Enable drop ends a held heat run once min-on is met
        run(1'b1, 1'b0, 1'b1, 3'd1, 2);
        run(1'b1, 1'b0, 1'b1, 3'd2, 8);
        run(1'b1, 1'b0, 1'b0, 3'd4, 3);
        run(1'b1, 1'b0, 1'b0, 3'd5, 6);
        run(1'b1, 1'b0, 1'b0, 3'd0, 1);

        // Cool request held through REST is taken after one IDLE cycle
        run(1'b1, 1'b0, 1'b1, 3'd1, 2);
        run(1'b1, 1'b0, 1'b1, 3'd2, 1);
        run(1'b0, 1'b0, 1'b1, 3'd2, 7);
        run(1'b0, 1'b0, 1'b1, 3'd4, 3);
        run(1'b0, 1'b1, 1'b1, 3'd5, 6);
        run(1'b0, 1'b1, 1'b1, 3'd0, 1);
        run(1'b0, 1'b1, 1'b1, 3'd1, 2);
        run(1'b0, 1'b1, 1'b1, 3'd3, 3);
        run(1'b0, 1'b0, 1'b1, 3'd3, 5);
        run(1'b0, 1'b0, 1'b1, 3'd4, 3);
        run(1'b0, 1'b0, 1'b1, 3'd5, 6);
        run(1'b0, 1'b0, 1'b1, 3'd0, 1);

        // Async reset mid RUN_HEAT, then restart with heat still requested
        run(1'b1, 1'b0, 1'b1, 3'd1, 2);
        run(1'b1, 1'b0, 1'b1, 3'd2, 3);
        drain();
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_heater", int'(heater_on), 0);
        chk("async_rst_fan", int'(fan_on), 0);
        #1 rst = 1'b0;
        run(1'b1, 1'b0, 1'b1, 3'd1, 2);
        run(1'b1, 1'b0, 1'b1, 3'd2, 1);
        run(1'b0, 1'b0, 1'b1, 3'd2, 7);
        run(1'b0, 1'b0, 1'b1, 3'd4, 3);
        run(1'b0, 1'b0, 1'b1, 3'd5, 6);
        run(1'b0, 1'b0, 1'b1, 3'd0, 1);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
